mem_wb: RTL and testbench

//  Memory stage plus MEM/WB pipeline register; receiving end of the ex_mem handshake.
//  - Holds mem_valid for the instruction presented on mem_* by ex_mem and drives mem_allowin back.
//  - For loads, runs the data-bus read and sign/zero-formats the returned word.
//  - Registers the writeback payload for the WB stage, with valid/allowin flow control toward WB.

---
 rtl/mem_wb_if.sv | 31 +++
 rtl/mem_wb.sv | 153 +++++++++++++++
 tb/tb_mem_wb.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_if.sv
// Data-bus read channel between the memory stage (master) and the data memory (slave).
//   dbus_req    master->slave  read request, held until dbus_gnt
//   dbus_addr   master->slave  word-aligned read address
//   dbus_gnt    slave->master  request accepted this cycle
//   dbus_rvalid slave->master  read data valid (never in the same cycle as its gnt)
//   dbus_rdata  slave->master  read data word
interface mem_wb_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            dbus_req;
  logic [XLEN-1:0] dbus_addr;
  logic            dbus_gnt;
  logic            dbus_rvalid;
  logic [XLEN-1:0] dbus_rdata;

  modport master (
    output dbus_req,
    output dbus_addr,
    input  dbus_gnt,
    input  dbus_rvalid,
    input  dbus_rdata
  );

  modport slave (
    input  dbus_req,
    input  dbus_addr,
    output dbus_gnt,
    output dbus_rvalid,
    output dbus_rdata
  );
endinterface

// File: rtl/mem_wb.sv
// Memory stage plus MEM/WB pipeline register.
// Accepts instructions from ex_mem (ex_mem_valid / mem_allowin), runs the data-bus read for
// loads, formats the returned word and registers the writeback payload toward WB
// (mem_wb_valid / wb_allowin).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   pipe_flush          kill in-flight MEM/WB content
//   ex_mem_valid        upstream has an instruction; mem_allowin: MEM can accept
//   wb_allowin          WB can accept; mem_wb_valid: MEM result ready for WB
//   mem_*               fields of the instruction currently in MEM
//   bus                 data-bus read channel (master side)
//   wb_*                registered writeback payload
module mem_wb #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RF_AW = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pipe_flush,
  input  logic             ex_mem_valid,
  output logic             mem_allowin,
  input  logic             wb_allowin,
  output logic             mem_wb_valid,
  input  logic [XLEN-1:0]  mem_pc,
  input  logic [XLEN-1:0]  mem_inst,
  input  logic             mem_req_rf,
  input  logic [RF_AW-1:0] mem_rf_waddr,
  input  logic [XLEN-1:0]  mem_alu_res,
  input  logic             mem_is_load,
  input  logic [1:0]       mem_ls_addr_2low,
  input  logic [4:0]       mem_l_mask,
  input  logic             mem_exp_flag,
  mem_wb_if.master         bus,
  output logic [XLEN-1:0]  wb_pc,
  output logic             wb_req_rf,
  output logic [RF_AW-1:0] wb_rf_waddr,
  output logic [XLEN-1:0]  wb_wdata
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StDrain} state_e;

  state_e          state_q, state_d;
  logic            mem_valid_q, mem_valid_d;
  logic [XLEN-1:0] ld_word_q, ld_word_d;
  logic            mem_ready_go;
  logic            wb_load;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_fmt;

  // The instruction word travels with the stage for tracing only.
  logic unused_inst;
  assign unused_inst = ^mem_inst;

  assign mem_ready_go = !mem_is_load || mem_exp_flag || (state_q == StDone);
  assign mem_wb_valid = mem_valid_q && mem_ready_go;
  // DRAIN still owes the bus one rvalid, so nothing new may enter until it is absorbed.
  assign mem_allowin  = (state_q != StDrain) && (!mem_valid_q || (mem_ready_go && wb_allowin));
  assign wb_load      = mem_wb_valid && wb_allowin;

  assign bus.dbus_req  = (state_q == StReq);
  assign bus.dbus_addr = {mem_alu_res[XLEN-1:2], 2'b00};

  always_comb begin
    mem_valid_d = mem_valid_q;
    if (pipe_flush) begin
      mem_valid_d = 1'b0;
    end else if (mem_allowin) begin
      mem_valid_d = ex_mem_valid;
    end
  end

  always_comb begin
    state_d   = state_q;
    ld_word_d = ld_word_q;
    unique case (state_q)
      StIdle: begin
        if (mem_valid_q && mem_is_load && !mem_exp_flag && !pipe_flush) state_d = StReq;
      end
      StReq: begin
        // A grant in the flush cycle still leaves a read outstanding.
        if (bus.dbus_gnt) begin
          state_d = pipe_flush ? StDrain : StWait;
        end else if (pipe_flush) begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (bus.dbus_rvalid) begin
          if (pipe_flush) begin
            state_d = StIdle;
          end else begin
            state_d   = StDone;
            ld_word_d = bus.dbus_rdata;
          end
        end else if (pipe_flush) begin
          state_d = StDrain;
        end
      end
      StDone: begin
        if (pipe_flush || wb_load) state_d = StIdle;
      end
      StDrain: begin
        if (bus.dbus_rvalid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    unique case (mem_ls_addr_2low)
      2'd0:    ld_byte = ld_word_q[7:0];
      2'd1:    ld_byte = ld_word_q[15:8];
      2'd2:    ld_byte = ld_word_q[23:16];
      default: ld_byte = ld_word_q[31:24];
    endcase
    ld_half = mem_ls_addr_2low[1] ? ld_word_q[31:16] : ld_word_q[15:0];
    unique case (mem_l_mask)
      5'b00001: ld_fmt = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      5'b00010: ld_fmt = {{(XLEN-8){1'b0}}, ld_byte};
      5'b00100: ld_fmt = {{(XLEN-16){ld_half[15]}}, ld_half};
      5'b01000: ld_fmt = {{(XLEN-16){1'b0}}, ld_half};
      default:  ld_fmt = ld_word_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mem_valid_q <= 1'b0;
      ld_word_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      ld_word_q   <= ld_word_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || pipe_flush) begin
      wb_pc       <= '0;
      wb_req_rf   <= 1'b0;
      wb_rf_waddr <= '0;
      wb_wdata    <= '0;
    end else if (wb_load) begin
      wb_pc       <= mem_pc;
      wb_req_rf   <= mem_req_rf;
      wb_rf_waddr <= mem_rf_waddr;
      wb_wdata    <= (mem_is_load && !mem_exp_flag) ? ld_fmt : mem_alu_res;
    end
  end

endmodule

// File: tb/tb_mem_wb.sv
module tb_mem_wb;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned RF_AW = 5;

  localparam logic [4:0] LB  = 5'b00001;
  localparam logic [4:0] LBU = 5'b00010;
  localparam logic [4:0] LH  = 5'b00100;
  localparam logic [4:0] LHU = 5'b01000;
  localparam logic [4:0] LW  = 5'b10000;

  logic             clk;
  logic             rst_n;
  logic             pipe_flush;
  logic             ex_mem_valid;
  logic             mem_allowin;
  logic             wb_allowin;
  logic             mem_wb_valid;
  logic [XLEN-1:0]  mem_pc;
  logic [XLEN-1:0]  mem_inst;
  logic             mem_req_rf;
  logic [RF_AW-1:0] mem_rf_waddr;
  logic [XLEN-1:0]  mem_alu_res;
  logic             mem_is_load;
  logic [1:0]       mem_ls_addr_2low;
  logic [4:0]       mem_l_mask;
  logic             mem_exp_flag;
  logic [XLEN-1:0]  wb_pc;
  logic             wb_req_rf;
  logic [RF_AW-1:0] wb_rf_waddr;
  logic [XLEN-1:0]  wb_wdata;

  mem_wb_if #(.XLEN(XLEN)) bus ();

  mem_wb #(.XLEN(XLEN), .RF_AW(RF_AW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pipe_flush       (pipe_flush),
    .ex_mem_valid     (ex_mem_valid),
    .mem_allowin      (mem_allowin),
    .wb_allowin       (wb_allowin),
    .mem_wb_valid     (mem_wb_valid),
    .mem_pc           (mem_pc),
    .mem_inst         (mem_inst),
    .mem_req_rf       (mem_req_rf),
    .mem_rf_waddr     (mem_rf_waddr),
    .mem_alu_res      (mem_alu_res),
    .mem_is_load      (mem_is_load),
    .mem_ls_addr_2low (mem_ls_addr_2low),
    .mem_l_mask       (mem_l_mask),
    .mem_exp_flag     (mem_exp_flag),
    .bus              (bus),
    .wb_pc            (wb_pc),
    .wb_req_rf        (wb_req_rf),
    .wb_rf_waddr      (wb_rf_waddr),
    .wb_wdata         (wb_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One instruction: stimulus plus its expected writeback and latency (edges after handover).
  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic        is_load;
    logic        exp;
    logic [4:0]  mask;
    logic [31:0] rdata;
    int          gnt_dly;
    int          rv_dly;
    logic        req_rf;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    int          lat;
    int          edge_no;
  } ins_t;

  typedef struct {
    logic [4:0]  mask;
    logic [1:0]  a;
    logic [31:0] rdata;
    int          gd;
    logic [31:0] exp;
  } vec_t;

  ins_t        ex_q[$];
  ins_t        sb_q[$];
  ins_t        cur;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          n_upd   = 0;
  logic        s_allowin, s_req;
  logic        req_seen;
  logic        rv_pend;
  int          rv_cnt, req_cnt;
  logic [31:0] rd_word;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic ins_t mk(input logic [31:0] pc, input logic [31:0] alu, input logic ld,
                              input logic ex, input logic [4:0] mask, input logic [31:0] rdata,
                              input int gd, input int rd, input logic [31:0] wdata,
                              input int lat);
    ins_t r;
    r.pc      = pc;
    r.alu     = alu;
    r.is_load = ld;
    r.exp     = ex;
    r.mask    = mask;
    r.rdata   = rdata;
    r.gnt_dly = gd;
    r.rv_dly  = rd;
    r.waddr   = pc[6:2];
    r.req_rf  = pc[2] ^ pc[3];
    r.wdata   = wdata;
    r.lat     = lat;
    r.edge_no = 0;
    return r;
  endfunction

  // One clock: sample before the edge, then score WB, model the bus and hand over from ex_mem.
  task automatic tick();
    logic hand, upd, gnt_acc;
    ins_t e;
    @(negedge clk);
    s_allowin = mem_allowin;
    s_req     = bus.dbus_req;
    if (bus.dbus_req) req_seen = 1'b1;
    hand    = rst_n && !pipe_flush && ex_mem_valid && mem_allowin;
    upd     = rst_n && !pipe_flush && mem_wb_valid && wb_allowin;
    gnt_acc = rst_n && bus.dbus_req && bus.dbus_gnt;
    if (gnt_acc) chk("dbus_addr", bus.dbus_addr, {cur.alu[31:2], 2'b00});
    @(posedge clk);
    #1;
    cyc++;
    if (upd) begin
      n_upd++;
      if (sb_q.size() == 0) begin
        chk("wb_spurious", wb_pc, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("wb_pc", wb_pc, e.pc);
        chk("wb_wdata", wb_wdata, e.wdata);
        chk("wb_rf", 32'({wb_req_rf, wb_rf_waddr}), 32'({e.req_rf, e.waddr}));
        chk("wb_edge", 32'(cyc), 32'(e.edge_no));
      end
    end
    bus.dbus_gnt    = 1'b0;
    bus.dbus_rvalid = 1'b0;
    if (gnt_acc) begin
      rv_pend = 1'b1;
      rv_cnt  = cur.rv_dly;
      rd_word = cur.rdata;
      req_cnt = 0;
    end
    if (rv_pend) begin
      if (rv_cnt == 0) begin
        bus.dbus_rvalid = 1'b1;
        bus.dbus_rdata  = rd_word;
        rv_pend         = 1'b0;
      end else begin
        rv_cnt--;
      end
    end
    if (bus.dbus_req) begin
      bus.dbus_gnt = (req_cnt >= cur.gnt_dly);
      req_cnt++;
    end else begin
      req_cnt = 0;
    end
    if (hand) begin
      cur              = ex_q.pop_front();
      cur.edge_no      = cyc + cur.lat;
      mem_pc           = cur.pc;
      mem_inst         = cur.pc ^ 32'h13;
      mem_req_rf       = cur.req_rf;
      mem_rf_waddr     = cur.waddr;
      mem_alu_res      = cur.alu;
      mem_is_load      = cur.is_load;
      mem_ls_addr_2low = cur.alu[1:0];
      mem_l_mask       = cur.mask;
      mem_exp_flag     = cur.exp;
      sb_q.push_back(cur);
    end
    ex_mem_valid = (ex_q.size() != 0);
  endtask

  task automatic drain(input int max);
    int k;
    k = 0;
    while ((ex_q.size() != 0 || sb_q.size() != 0) && k < max) begin
      tick();
      k++;
    end
    chk("drain_left", 32'(ex_q.size() + sb_q.size()), 32'd0);
    ex_q.delete();
    sb_q.delete();
    ex_mem_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[11];
    int          n0;
    logic [31:0] prev_pc, prev_wd;

    vt[0]  = '{LB,  2'd3, 32'h80FF_1234, 2, 32'hFFFF_FF80};
    vt[1]  = '{LHU, 2'd2, 32'h8001_0000, 0, 32'h0000_8001};
    vt[2]  = '{LH,  2'd2, 32'h8001_0000, 1, 32'hFFFF_8001};
    vt[3]  = '{LBU, 2'd0, 32'h80FF_1234, 0, 32'h0000_0034};
    vt[4]  = '{LBU, 2'd3, 32'h80FF_1234, 0, 32'h0000_0080};
    vt[5]  = '{LB,  2'd2, 32'h80FF_1234, 0, 32'hFFFF_FFFF};
    vt[6]  = '{LB,  2'd1, 32'h80FF_1234, 1, 32'h0000_0012};
    vt[7]  = '{LH,  2'd0, 32'h80FF_1234, 0, 32'h0000_1234};
    vt[8]  = '{LH,  2'd0, 32'h0000_F00D, 0, 32'hFFFF_F00D};
    vt[9]  = '{LW,  2'd0, 32'h80FF_1234, 3, 32'h80FF_1234};
    vt[10] = '{LBU, 2'd1, 32'h0000_A500, 0, 32'h0000_00A5};

    rst_n = 1'b0; pipe_flush = 1'b0; ex_mem_valid = 1'b0; wb_allowin = 1'b1;
    mem_pc = '0; mem_inst = '0; mem_req_rf = 1'b0; mem_rf_waddr = '0; mem_alu_res = '0;
    mem_is_load = 1'b0; mem_ls_addr_2low = '0; mem_l_mask = '0; mem_exp_flag = 1'b0;
    bus.dbus_gnt = 1'b0; bus.dbus_rvalid = 1'b0; bus.dbus_rdata = '0;
    rv_pend = 1'b0; rv_cnt = 0; req_cnt = 0; rd_word = '0; req_seen = 1'b0;
    cur = mk(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 0, 0, 32'h0, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_pc", wb_pc, 32'h0);
    chk("rst_wb_wdata", wb_wdata, 32'h0);
    chk("rst_wb_rf", 32'({wb_req_rf, wb_rf_waddr}), 32'h0);
    chk("rst_dbus_req", 32'(bus.dbus_req), 32'h0);
    chk("rst_mem_wb_valid", 32'(mem_wb_valid), 32'h0);
    chk("rst_mem_allowin", 32'(mem_allowin), 32'h1);
    rst_n = 1'b1;

    // Back-to-back ALU ops: one WB update per cycle.
    ex_q.push_back(mk(32'h104, 32'h11, 1'b0, 1'b0, 5'd0, 32'h0, 0, 0, 32'h11, 1));
    ex_q.push_back(mk(32'h108, 32'h22, 1'b0, 1'b0, 5'd0, 32'h0, 0, 0, 32'h22, 1));
    ex_q.push_back(mk(32'h10C, 32'h33, 1'b0, 1'b0, 5'd0, 32'h0, 0, 0, 32'h33, 1));
    ex_mem_valid = 1'b1;
    n0 = n_upd;
    repeat (4) tick();
    chk("b2b_updates", 32'(n_upd - n0), 32'd3);
    drain(10);

    // Load formatting table, issued back-to-back.
    for (int i = 0; i < 11; i++) begin
      ex_q.push_back(mk(32'h200 + 32'(4 * i), 32'h1000 + 32'(16 * i) + 32'(vt[i].a), 1'b1, 1'b0,
                        vt[i].mask, vt[i].rdata, vt[i].gd, 0, vt[i].exp, 4 + vt[i].gd));
    end
    ex_mem_valid = 1'b1;
    drain(200);

    // Excepting load: no bus access, ALU result the cycle after acceptance.
    req_seen = 1'b0;
    ex_q.push_back(mk(32'h300, 32'hCAFE_0001, 1'b1, 1'b1, LW, 32'h0, 0, 0, 32'hCAFE_0001, 1));
    ex_mem_valid = 1'b1;
    drain(10);
    chk("exp_no_req", 32'(req_seen), 32'h0);

    // Load held in DONE while WB stalls for 3 cycles; follower enters on the handover edge.
    ex_q.push_back(mk(32'h404, 32'h2002, 1'b1, 1'b0, LHU, 32'h8001_0000, 0, 0, 32'h0000_8001, 7));
    ex_q.push_back(mk(32'h408, 32'h44, 1'b0, 1'b0, 5'd0, 32'h0, 0, 0, 32'h44, 1));
    wb_allowin   = 1'b0;
    ex_mem_valid = 1'b1;
    tick();
    prev_pc = wb_pc;
    prev_wd = wb_wdata;
    repeat (3) tick();
    repeat (3) begin
      tick();
      chk("stall_allowin", 32'(s_allowin), 32'h0);
      chk("stall_hold_pc", wb_pc, prev_pc);
      chk("stall_hold_wdata", wb_wdata, prev_wd);
    end
    wb_allowin = 1'b1;
    drain(10);

    // Flush while the read is outstanding: DRAIN blocks intake until the rvalid is absorbed.
    ex_q.push_back(mk(32'h500, 32'h3000, 1'b1, 1'b0, LW, 32'hBADC_0DE5, 0, 3, 32'hBADC_0DE5, 5));
    ex_mem_valid = 1'b1;
    repeat (3) tick();
    chk("wait_read_pending", 32'(rv_pend), 32'h1);
    pipe_flush = 1'b1;
    tick();
    pipe_flush = 1'b0;
    sb_q.delete();
    chk("flush_wb_pc", wb_pc, 32'h0);
    chk("flush_wb_wdata", wb_wdata, 32'h0);
    chk("flush_wb_rf", 32'({wb_req_rf, wb_rf_waddr}), 32'h0);
    ex_q.push_back(mk(32'h504, 32'h55, 1'b0, 1'b0, 5'd0, 32'h0, 0, 0, 32'h55, 1));
    ex_mem_valid = 1'b1;
    repeat (3) begin
      tick();
      chk("drain_allowin", 32'(s_allowin), 32'h0);
    end
    tick();
    chk("post_drain_allowin", 32'(s_allowin), 32'h1);
    drain(10);

    // Reset in the middle of WAIT.
    ex_q.push_back(mk(32'h604, 32'h4000, 1'b1, 1'b0, LW, 32'h1234_5678, 0, 5, 32'h1234_5678, 9));
    ex_mem_valid = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rv_pend = 1'b0;
    bus.dbus_rvalid = 1'b0;
    sb_q.delete();
    chk("rstw_dbus_req", 32'(bus.dbus_req), 32'h0);
    chk("rstw_wb_pc", wb_pc, 32'h0);
    chk("rstw_wb_wdata", wb_wdata, 32'h0);
    chk("rstw_wb_rf", 32'({wb_req_rf, wb_rf_waddr}), 32'h0);
    chk("rstw_mem_wb_valid", 32'(mem_wb_valid), 32'h0);
    chk("rstw_mem_allowin", 32'(mem_allowin), 32'h1);
    tick();
    chk("rstw_idle_req", 32'(s_req), 32'h0);
    ex_q.push_back(mk(32'h704, 32'h77, 1'b0, 1'b0, 5'd0, 32'h0, 0, 0, 32'h77, 1));
    ex_mem_valid = 1'b1;
    drain(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
